// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter that shares one writeback bus between three requesters.
// A per-tenure transfer limit forces rotation when another requester is waiting.
module wb_bus_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic             ReqC,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic [WIDTH-1:0] DataC,
  output logic             GntA,
  output logic             GntB,
  output logic             GntC,
  output logic [1:0]       Sel,
  output logic [WIDTH-1:0] OutData,
  output logic             OutValid,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    OWN_C = 2'd3
  } arbStateT;

  localparam logic [4:0] holdLimit = 5'(MAX_HOLD);

  arbStateT         state, stateNext;
  logic [1:0]       lastOwner, lastOwnerNext;
  logic [3:0]       holdCnt, holdCntNext;
  logic [1:0]       selNext;
  logic [2:0]       req;
  logic [1:0]       ownerIdx, searchBase, cand1, cand2;
  logic [4:0]       holdInc;
  logic             transfer;
  logic             otherWaiting;
  logic [WIDTH-1:0] ownerData;

  function automatic logic [1:0] rrNext(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic arbStateT ownState(input logic [1:0] idx);
    case (idx)
      2'd0:    return OWN_A;
      2'd1:    return OWN_B;
      default: return OWN_C;
    endcase
  endfunction

  assign req        = {ReqC, ReqB, ReqA};
  assign ownerIdx   = state - 2'd1;
  assign searchBase = (state == IDLE) ? lastOwner : ownerIdx;
  assign cand1      = rrNext(searchBase);
  assign cand2      = rrNext(cand1);

  // Owner release and tenure expiry both hand over to the next requester in
  // RR order without a bubble; the current owner itself is never a candidate.
  always_comb begin
    stateNext     = state;
    lastOwnerNext = lastOwner;
    holdCntNext   = holdCnt;
    selNext       = Sel;
    transfer      = 1'b0;
    otherWaiting  = req[cand1] | req[cand2];
    holdInc       = {1'b0, holdCnt} + 5'd1;
    ownerData     = DataA;

    case (ownerIdx)
      2'd1:    ownerData = DataB;
      2'd2:    ownerData = DataC;
      default: ownerData = DataA;
    endcase

    if (state == IDLE) begin
      holdCntNext = '0;
      if (req[cand1])          stateNext = ownState(cand1);
      else if (req[cand2])     stateNext = ownState(cand2);
      else if (req[searchBase]) stateNext = ownState(searchBase);
    end else begin
      transfer = req[ownerIdx];
      // Saturated counts still count as expired so contention always rotates.
      if (!transfer || (holdInc >= holdLimit && otherWaiting)) begin
        lastOwnerNext = ownerIdx;
        holdCntNext   = '0;
        if (req[cand1])      stateNext = ownState(cand1);
        else if (req[cand2]) stateNext = ownState(cand2);
        else                 stateNext = IDLE;
      end else begin
        holdCntNext = (holdInc > holdLimit) ? holdLimit[3:0] : holdInc[3:0];
      end
    end

    if (stateNext != IDLE) selNext = stateNext - 2'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      lastOwner <= 2'd2;
      holdCnt   <= '0;
      Sel       <= 2'd0;
      OutData   <= '0;
      OutValid  <= 1'b0;
    end else begin
      state     <= stateNext;
      lastOwner <= lastOwnerNext;
      holdCnt   <= holdCntNext;
      Sel       <= selNext;
      OutValid  <= transfer;
      if (transfer) OutData <= ownerData;
    end
  end

  assign GntA = (state == OWN_A);
  assign GntB = (state == OWN_B);
  assign GntC = (state == OWN_C);
  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: a behavioural owner/tenure model is
// compared every falling edge, plus directed scenarios with literal expectations.
module tb_wb_bus_arbiter;

  localparam int WIDTH    = 32;
  localparam int MAX_HOLD = 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             ReqA = 1'b0, ReqB = 1'b0, ReqC = 1'b0;
  logic [WIDTH-1:0] DataA = '0, DataB = '0, DataC = '0;
  logic             GntA, GntB, GntC;
  logic [1:0]       Sel;
  logic [WIDTH-1:0] OutData;
  logic             OutValid;
  logic             Busy;

  int checkCount = 0;
  int passCount  = 0;

  int               mOwner = -1;
  int               mLast  = 2;
  int               mHold  = 0;
  int               mSel   = 0;
  logic             mValid = 1'b0;
  logic [WIDTH-1:0] mData  = '0;

  wb_bus_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA(ReqA), .ReqB(ReqB), .ReqC(ReqC),
    .DataA(DataA), .DataB(DataB), .DataC(DataC),
    .GntA(GntA), .GntB(GntB), .GntC(GntC),
    .Sel(Sel), .OutData(OutData), .OutValid(OutValid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic ra, input logic rb, input logic rc,
                               input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                               input logic [WIDTH-1:0] dc);
    ReqA = ra; ReqB = rb; ReqC = rc;
    DataA = da; DataB = db; DataC = dc;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic resetPulse();
    Reset = 1'b1;
    waitCycles(1);
    Reset = 1'b0;
  endtask

  function automatic int firstAfter(input int base, input int span, input logic [2:0] r);
    for (int k = 1; k <= span; k++) begin
      if (r[(base + k) % 3]) return (base + k) % 3;
    end
    return -1;
  endfunction

  // Reference model: who owns the bus, how many words this tenure, what was sent.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mOwner = -1; mLast = 2; mHold = 0; mSel = 0; mValid = 1'b0; mData = '0;
    end else begin
      logic [2:0] r;
      int other;
      r = {ReqC, ReqB, ReqA};
      mValid = 1'b0;
      if (mOwner < 0) begin
        mOwner = firstAfter(mLast, 3, r);
        mHold = 0;
      end else begin
        other = firstAfter(mOwner, 2, r);
        if (r[mOwner]) begin
          mValid = 1'b1;
          mData = (mOwner == 0) ? DataA : (mOwner == 1) ? DataB : DataC;
          if (mHold + 1 >= MAX_HOLD && other >= 0) begin
            mLast = mOwner; mOwner = other; mHold = 0;
          end else begin
            mHold = (mHold + 1 > MAX_HOLD) ? MAX_HOLD : mHold + 1;
          end
        end else begin
          mLast = mOwner; mOwner = other; mHold = 0;
        end
      end
      if (mOwner >= 0) mSel = mOwner;
    end
  end

  always @(negedge Clk) begin
    checkOutput("modelGnt", 64'({GntC, GntB, GntA}), (mOwner < 0) ? 64'd0 : 64'(1 << mOwner));
    checkOutput("modelSel", 64'(Sel), 64'(mSel));
    checkOutput("modelValid", 64'(OutValid), 64'(mValid));
    checkOutput("modelData", 64'(OutData), 64'(mData));
    checkOutput("modelBusy", 64'(Busy), 64'(mOwner >= 0));
  end

  initial begin
    logic ra, rb, rc;

    // Reset held with A requesting, then first grant and first word.
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h1111_1111, '0, '0);
    waitCycles(2);
    checkOutput("rstGnt", 64'({GntC, GntB, GntA}), 64'd0);
    checkOutput("rstSel", 64'(Sel), 64'd0);
    checkOutput("rstValid", 64'(OutValid), 64'd0);
    checkOutput("rstData", 64'(OutData), 64'd0);
    checkOutput("rstBusy", 64'(Busy), 64'd0);
    Reset = 1'b0;
    waitCycles(1);
    checkOutput("firstGntA", 64'(GntA), 64'd1);
    waitCycles(1);
    checkOutput("firstData", 64'(OutData), 64'h1111_1111);
    checkOutput("firstValid", 64'(OutValid), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    waitCycles(3);

    // Single requester streaming never rotates.
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 32'h100, '0);
    waitCycles(1);
    for (int i = 0; i < 10; i++) begin
      DataB = 32'h100 + 32'(i);
      waitCycles(1);
      checkOutput("streamData", 64'(OutData), 64'(32'h100 + 32'(i)));
      checkOutput("streamGntB", 64'({GntC, GntB, GntA}), 64'b010);
      checkOutput("streamSel", 64'(Sel), 64'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    waitCycles(2);

    // Full contention: A x4, B x4, C x4, A x4 with no bubbles.
    resetPulse();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hA000_0000, 32'hB000_0000, 32'hC000_0000);
    for (int k = 0; k < 16; k++) begin
      waitCycles(1);
      checkOutput("rotGnt", 64'({GntC, GntB, GntA}), 64'(1 << ((k / 4) % 3)));
      if (k >= 1) checkOutput("rotValid", 64'(OutValid), 64'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    waitCycles(2);

    // Early release by A goes straight to C, skipping idle B.
    resetPulse();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hAAAA_0001, '0, 32'hCCCC_0001);
    waitCycles(1);
    checkOutput("earlyGntA", 64'({GntC, GntB, GntA}), 64'b001);
    waitCycles(1);
    checkOutput("earlyA1", 64'(OutData), 64'hAAAA_0001);
    DataA = 32'hAAAA_0002;
    waitCycles(1);
    checkOutput("earlyA2", 64'(OutData), 64'hAAAA_0002);
    ReqA = 1'b0;
    waitCycles(1);
    checkOutput("earlyGntC", 64'({GntC, GntB, GntA}), 64'b100);
    checkOutput("earlyGap", 64'(OutValid), 64'd0);
    waitCycles(1);
    checkOutput("earlyC1", 64'(OutData), 64'hCCCC_0001);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    waitCycles(2);

    // LastOwner = B, then A and C together: C first, A after C releases.
    resetPulse();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 32'hBBBB_0001, '0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    waitCycles(2);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hAAAA_0003, '0, 32'hCCCC_0003);
    waitCycles(1);
    checkOutput("simulGntC", 64'({GntC, GntB, GntA}), 64'b100);
    ReqC = 1'b0;
    waitCycles(1);
    checkOutput("simulGntA", 64'({GntC, GntB, GntA}), 64'b001);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    waitCycles(2);

    // Asynchronous reset in the middle of C's tenure.
    resetPulse();
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 32'hCCCC_0004);
    waitCycles(2);
    checkOutput("midValid", 64'(OutValid), 64'd1);
    ReqA = 1'b1;
    DataA = 32'hAAAA_0004;
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    checkOutput("midRstGnt", 64'({GntC, GntB, GntA}), 64'd0);
    checkOutput("midRstValid", 64'(OutValid), 64'd0);
    checkOutput("midRstData", 64'(OutData), 64'd0);
    checkOutput("midRstBusy", 64'(Busy), 64'd0);
    waitCycles(1);
    Reset = 1'b0;
    waitCycles(1);
    checkOutput("midRstGntA", 64'({GntC, GntB, GntA}), 64'b001);

    // Random traffic with sticky requests so tenures run long.
    for (int n = 0; n < 2000; n++) begin
      ra = ReqA ^ ($urandom_range(0, 3) == 0);
      rb = ReqB ^ ($urandom_range(0, 3) == 0);
      rc = ReqC ^ ($urandom_range(0, 3) == 0);
      applyStimulus(ra, rb, rc, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 499) == 0) resetPulse();
      else waitCycles(1);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    waitCycles(2);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Round-robin arbiter that shares one 32-bit writeback path between three requesters (A, B, C). It drives the select of the downstream 3-to-1 word mux and registers the winning word onto the shared bus. A tenure limit stops any one requester from starving the others. The block sits between the producing units (ALU result, load data, link/PC+4 path) and the register-file write port.

## Interface
- WIDTH, 32, data word width
- MAX_HOLD, 4, maximum consecutive transfers per tenure while another requester is waiting (legal 1..15)

- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state immediately
- ReqA / ReqB / ReqC  in  1 each  request; held high while the requester has a word to send
- DataA / DataB / DataC  in  WIDTH each  requester word, valid whenever its Req is high
- GntA / GntB / GntC  out  1 each  registered one-hot grant (all low = idle)
- Sel  out  2  mux select: 00 = A, 01 = B, 10 = C; never 11
- OutData  out  WIDTH  registered bus word
- OutValid  out  1  OutData carries a transfer this cycle
- Busy  out  1  high whenever any Gnt is high

## Operation
- States: IDLE (no grant) and OWN(x), x in {A, B, C}.
- Internal regs: LastOwner (2 bits) and HoldCnt (4 bits, counts transfers completed in the current tenure).
- Round-robin order is A→B→C→A. The search starts at the requester after LastOwner.
- IDLE: if any Req is high, go to OWN(first requesting in RR order) at the next edge and clear HoldCnt. Otherwise stay in IDLE.
- OWN(x), one decision per edge:
  - Req_x low: no transfer this cycle. Release the bus. Go to the next requesting in RR order, excluding x; if none, go to IDLE. There is no bubble when switching.
  - Req_x high: a transfer occurs this cycle.
    - If HoldCnt+1 == MAX_HOLD and another Req is high, rotate to that requester after this transfer.
    - Otherwise stay in OWN(x) and increment HoldCnt, saturating at MAX_HOLD.
  - On any change of owner: LastOwner <= x and HoldCnt <= 0.
- Sel always encodes the current owner. It holds its last value in IDLE.
- Transfer cycle (Gnt_x & Req_x): OutData <= Data_x and OutValid <= 1 at the next edge. Otherwise OutValid <= 0 and OutData holds its value.
- A requester can never receive an unrequested transfer. If a Req deasserts in the same cycle its grant lands, the grant is wasted and released next edge.

## Timing
- Reset values: Gnt* = 0, Sel = 00, OutData = 0, OutValid = 0, Busy = 0, state IDLE, HoldCnt = 0, LastOwner = C (so A wins first).
- Request to grant: one cycle. Req sampled high at edge N gives Gnt high after edge N.
- Grant to bus: one cycle. A transfer in cycle N appears on OutData/OutValid in cycle N+1.
- Sustained throughput is one word per cycle, including across owner switches.
- With contention, each requester gets at most MAX_HOLD transfers per tenure. The worst-case wait is 2·MAX_HOLD cycles.
- Simultaneous requests resolve purely by RR order relative to LastOwner.
- Reset asserted mid-tenure: all outputs clear asynchronously, and any in-flight OutValid is dropped. After release the block restarts from IDLE with A highest priority.

## Test plan
- Reset: hold Reset with ReqA=1 → Gnt*=000, Sel=00, OutValid=0, OutData=0. Release → GntA=1 one cycle later; DataA=0x11111111 appears on OutData the following cycle.
- Single requester streaming: ReqB=1 for 10 cycles, DataB incrementing from 0x100 → GntB stays high the whole time (no rotation without contention), Sel=01. OutData carries 0x100..0x109 on consecutive cycles, each one cycle after its transfer.
- Contention rotation: ReqA=ReqB=ReqC=1 continuously, MAX_HOLD=4 → grants run A×4, B×4, C×4, A×4. There are no idle cycles, and OutValid stays high continuously after the first word.
- Early release: A owns the bus and drops ReqA after 2 transfers while ReqC=1 → the next edge grants C directly (skipping non-requesting B); OutValid shows exactly 2 A words, then C words.
- Simultaneous request after idle: LastOwner=B, then ReqA and ReqC rise in the same cycle → C wins; after C releases, A is granted.
- Reset mid-tenure: assert Reset asynchronously between edges while C owns the bus and OutValid=1 → all outputs drop immediately. After release with ReqA=ReqC=1, A is granted first.
